// File: rtl/gppcu_instr_queue_sc_if.sv
// Handshake and status bundle between the host command path and the GPPCU instruction queue.
// The queue side uses the slave modport; the host/command side uses master.
interface gppcu_instr_queue_sc_if #(
    parameter int DBW = 32,
    parameter int QBW = 10
);
    logic           flush;
    logic           wr_valid;
    logic           wr_ready;
    logic [DBW-1:0] wr_data;
    logic           rd_valid;
    logic           rd_ready;
    logic [DBW-1:0] rd_data;
    logic [QBW:0]   count;
    logic           empty;
    logic           full;
    logic           almost_full;
    logic           core_idle;
    logic           done;
    logic [1:0]     err;

    modport master (
        output flush, wr_valid, wr_data, rd_ready, core_idle,
        input  wr_ready, rd_valid, rd_data, count, empty, full, almost_full, done, err
    );

    modport slave (
        input  flush, wr_valid, wr_data, rd_ready, core_idle,
        output wr_ready, rd_valid, rd_data, count, empty, full, almost_full, done, err
    );
endinterface

// File: rtl/gppcu_instr_queue_sc.sv
// Single-clock first-word-fall-through instruction queue feeding GPPCU_CORE (DEPTH-1 RAM + output register).
// Optional sticky overflow/flush-discard flags are built only when GPPCU_QUEUE_ERR_EN is defined.
module gppcu_instr_queue_sc #(
    parameter int DBW       = 32,
    parameter int QBW       = 10,
    parameter int AF_MARGIN = 4
) (
    input logic clk,
    input logic rst,
    gppcu_instr_queue_sc_if.slave q
);
    localparam int DEPTH     = 1 << QBW;
    localparam int RAM_DEPTH = DEPTH - 1;
    localparam logic [QBW-1:0] PTR_LAST  = QBW'(RAM_DEPTH - 1);
    localparam logic [QBW:0]   CNT_FULL  = (QBW+1)'(DEPTH);
    localparam logic [QBW:0]   CNT_AF    = (QBW+1)'(DEPTH - AF_MARGIN);

    logic [DBW-1:0] mem [RAM_DEPTH];
    logic [QBW-1:0] wr_ptr;
    logic [QBW-1:0] rd_ptr;
    logic [QBW:0]   count_r;
    logic           rd_valid_r;
    logic [DBW-1:0] rd_data_r;

    logic full_w;
    logic push;
    logic pop;
    logic ram_nonempty;
    logic load;

    function automatic logic [QBW-1:0] next_ptr(input logic [QBW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Ready comes from the registered count only, so a same-cycle pop never opens a slot.
    assign full_w       = (count_r == CNT_FULL);
    assign push         = q.wr_valid & ~full_w;
    assign pop          = q.rd_valid & q.rd_ready;
    assign ram_nonempty = (count_r != {{QBW{1'b0}}, rd_valid_r});
    assign load         = ram_nonempty & (~rd_valid_r | pop);

    always_ff @(posedge clk) begin
        if (push && !rst && !q.flush) begin
            mem[wr_ptr] <= q.wr_data;
        end
    end

    // The output register is the RAM's read register: it refills whenever it empties or is popped.
    always_ff @(posedge clk) begin
        if (rst || q.flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_r    <= '0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (load) begin
                rd_data_r  <= mem[rd_ptr];
                rd_ptr     <= next_ptr(rd_ptr);
                rd_valid_r <= 1'b1;
            end else if (pop) begin
                rd_valid_r <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef GPPCU_QUEUE_ERR_EN
    logic [1:0] err_r;

    // Flags survive flush so the host can see that instructions were lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 2'b00;
        end else begin
            if (q.wr_valid && full_w) begin
                err_r[0] <= 1'b1;
            end
            if (q.flush && (count_r != '0)) begin
                err_r[1] <= 1'b1;
            end
        end
    end

    assign q.err = err_r;
`else
    assign q.err = 2'b00;
`endif

    assign q.wr_ready    = ~full_w;
    assign q.rd_valid    = rd_valid_r;
    assign q.rd_data     = rd_data_r;
    assign q.count       = count_r;
    assign q.empty       = (count_r == '0);
    assign q.full        = full_w;
    assign q.almost_full = (count_r >= CNT_AF);
    assign q.done        = (count_r == '0) & q.core_idle;
endmodule
